// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and bus widths for the IF/MEM external memory bus arbiter.
// Both masters use the same address/data widths.
package mem_bus_arbiter_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_SEL_W  = 4;

  localparam logic [MEM_SEL_W-1:0] IF_SEL = 4'b1111;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_GRANT_IF  = 2'd1,
    ARB_GRANT_MEM = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_watchdog.sv
// Per-transaction cycle counter; expired_o flags the last permitted wait cycle.
// The counter is held at zero while clear_i is high and advances only when enabled.
module mem_bus_arbiter_watchdog #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int COUNT_WIDTH    = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one req/ack memory bus between instruction fetch and data access.
// MEM has fixed priority; a watchdog aborts grants the slave never acknowledges.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int COUNT_WIDTH    = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [MEM_ADDR_W-1:0] if_addr,
  output logic [MEM_DATA_W-1:0] if_rdata,
  output logic                  if_ready,
  output logic                  if_error,
  output logic                  stall_from_if,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [MEM_SEL_W-1:0]  mem_sel,
  input  logic [MEM_DATA_W-1:0] mem_wdata,
  output logic [MEM_DATA_W-1:0] mem_rdata,
  output logic                  mem_ready,
  output logic                  mem_error,
  output logic                  stall_from_mem,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [MEM_ADDR_W-1:0] bus_addr,
  output logic [MEM_SEL_W-1:0]  bus_sel,
  output logic [MEM_DATA_W-1:0] bus_wdata,
  input  logic [MEM_DATA_W-1:0] bus_rdata,
  input  logic                  bus_ack,
  output logic [1:0]            arb_state
);

  arb_state_e state_q, state_d;
  logic bus_req_q, bus_req_d, bus_we_q, bus_we_d;
  logic [MEM_ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [MEM_SEL_W-1:0]  bus_sel_q, bus_sel_d;
  logic [MEM_DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [MEM_DATA_W-1:0] if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic if_ready_q, if_ready_d, if_error_q, if_error_d;
  logic mem_ready_q, mem_ready_d, mem_error_q, mem_error_d;
  logic wd_clear, wd_enable, wd_expired;
  logic eff_if, eff_mem;

  // A master's request is ignored in its own ready cycle: the pipeline consumes
  // the result on that edge, so the held request is already satisfied.
  assign eff_mem = mem_req && !mem_ready_q;
  assign eff_if  = if_req && !if_ready_q;

  mem_bus_arbiter_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .COUNT_WIDTH   (COUNT_WIDTH)
  ) u_watchdog (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (wd_clear),
    .enable_i (wd_enable),
    .expired_o(wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_sel_d   = bus_sel_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ready_d  = 1'b0;
    if_error_d  = 1'b0;
    mem_ready_d = 1'b0;
    mem_error_d = 1'b0;
    wd_clear    = 1'b0;
    wd_enable   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        wd_clear = 1'b1;
        if (eff_mem) begin
          state_d     = ARB_GRANT_MEM;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we;
          bus_addr_d  = mem_addr;
          bus_sel_d   = mem_sel;
          bus_wdata_d = mem_wdata;
        end else if (eff_if) begin
          state_d     = ARB_GRANT_IF;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr;
          bus_sel_d   = IF_SEL;
          bus_wdata_d = '0;
        end
      end
      ARB_GRANT_IF, ARB_GRANT_MEM: begin
        if (bus_ack) begin
          state_d   = ARB_IDLE;
          bus_req_d = 1'b0;
          if (state_q == ARB_GRANT_IF) begin
            if_rdata_d = bus_rdata;
            if_ready_d = 1'b1;
          end else begin
            mem_ready_d = 1'b1;
            if (!bus_we_q) mem_rdata_d = bus_rdata;
          end
        end else if (wd_expired) begin
          state_d   = ARB_IDLE;
          bus_req_d = 1'b0;
          if (state_q == ARB_GRANT_IF) begin
            if_rdata_d = '0;
            if_ready_d = 1'b1;
            if_error_d = 1'b1;
          end else begin
            mem_rdata_d = '0;
            mem_ready_d = 1'b1;
            mem_error_d = 1'b1;
          end
        end else begin
          wd_enable = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_sel_q   <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      if_error_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_sel_q   <= bus_sel_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ready_q  <= if_ready_d;
      if_error_q  <= if_error_d;
      mem_ready_q <= mem_ready_d;
      mem_error_q <= mem_error_d;
    end
  end

  assign bus_req        = bus_req_q;
  assign bus_we         = bus_we_q;
  assign bus_addr       = bus_addr_q;
  assign bus_sel        = bus_sel_q;
  assign bus_wdata      = bus_wdata_q;
  assign if_rdata       = if_rdata_q;
  assign if_ready       = if_ready_q;
  assign if_error       = if_error_q;
  assign mem_rdata      = mem_rdata_q;
  assign mem_ready      = mem_ready_q;
  assign mem_error      = mem_error_q;
  assign stall_from_if  = if_req && !if_ready_q;
  assign stall_from_mem = mem_req && !mem_ready_q;
  assign arb_state      = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: per-cycle vector table for the basic
// fetch and store/fetch collision, then hand-written multi-cycle sequences.
module tb_mem_bus_arbiter;

  logic        clock, reset;
  logic        if_req;
  logic [31:0] if_addr, if_rdata;
  logic        if_ready, if_error, stall_from_if;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_sel;
  logic        mem_ready, mem_error, stall_from_mem;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_sel;
  logic        bus_ack;
  logic [1:0]  arb_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  mem_bus_arbiter #(.TIMEOUT_CYCLES(16), .COUNT_WIDTH(5)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .if_error(if_error), .stall_from_if(stall_from_if),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_error(mem_error), .stall_from_mem(stall_from_mem),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .arb_state(arb_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_sel;
    logic [31:0] mem_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
  } vin_t;

  typedef struct {
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic        if_ready, if_error;
    logic [31:0] if_rdata;
    logic        mem_ready, mem_error;
    logic [31:0] mem_rdata;
    logic        stall_if, stall_mem;
  } vexp_t;

  localparam int NVEC = 14;
  vin_t  vin [NVEC];
  vexp_t vexp[NVEC];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_addr = 0;
    mem_sel = 0; mem_wdata = 0; bus_ack = 0; bus_rdata = 0;
  endtask

  task automatic apply_vec(input vin_t v);
    if_req = v.if_req; if_addr = v.if_addr; mem_req = v.mem_req; mem_we = v.mem_we;
    mem_addr = v.mem_addr; mem_sel = v.mem_sel; mem_wdata = v.mem_wdata;
    bus_ack = v.bus_ack; bus_rdata = v.bus_rdata;
  endtask

  task automatic check_vec(input int i, input vexp_t e);
    chk($sformatf("v%0d bus_req", i), 32'(bus_req), 32'(e.bus_req));
    chk($sformatf("v%0d bus_we", i), 32'(bus_we), 32'(e.bus_we));
    chk($sformatf("v%0d bus_addr", i), bus_addr, e.bus_addr);
    chk($sformatf("v%0d bus_sel", i), 32'(bus_sel), 32'(e.bus_sel));
    chk($sformatf("v%0d bus_wdata", i), bus_wdata, e.bus_wdata);
    chk($sformatf("v%0d if_ready", i), 32'(if_ready), 32'(e.if_ready));
    chk($sformatf("v%0d if_error", i), 32'(if_error), 32'(e.if_error));
    chk($sformatf("v%0d if_rdata", i), if_rdata, e.if_rdata);
    chk($sformatf("v%0d mem_ready", i), 32'(mem_ready), 32'(e.mem_ready));
    chk($sformatf("v%0d mem_error", i), 32'(mem_error), 32'(e.mem_error));
    chk($sformatf("v%0d mem_rdata", i), mem_rdata, e.mem_rdata);
    chk($sformatf("v%0d stall_if", i), 32'(stall_from_if), 32'(e.stall_if));
    chk($sformatf("v%0d stall_mem", i), 32'(stall_from_mem), 32'(e.stall_mem));
  endtask

  // MEM load to 0x300; ack_at selects which bus_req-high cycle gets the ack (0 = never).
  task automatic mem_load_watchdog(input string nm, input int ack_at, input logic exp_err,
                                   input logic [31:0] exp_rdata);
    int  hi;
    bit  done;
    hi = 0; done = 0;
    @(negedge clock);
    mem_req = 1; mem_we = 0; mem_addr = 32'h300; mem_sel = 4'hF; mem_wdata = 0;
    bus_ack = 0; bus_rdata = 32'h0BADF00D;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clock);
      if (bus_req) hi++;
      bus_ack = bus_req && (hi == ack_at);
      #1;
      if (mem_ready) begin
        done = 1;
        chk({nm, " bus_req_cycles"}, 32'(hi), 32'd16);
        chk({nm, " mem_error"}, 32'(mem_error), 32'(exp_err));
        chk({nm, " mem_rdata"}, mem_rdata, exp_rdata);
        chk({nm, " bus_req_dropped"}, 32'(bus_req), 32'd0);
      end
    end
    if (!done) chk({nm, " ready_seen"}, 32'd0, 32'd1);
    @(negedge clock);
    mem_req = 0; bus_ack = 0;
    #1;
    chk({nm, " ready_one_cycle"}, 32'(mem_ready), 32'd0);
    chk({nm, " error_one_cycle"}, 32'(mem_error), 32'd0);
  endtask

  initial begin
    int grants;
    bit prev_req;
    bit seen;

    // cycle-by-cycle table: fetch 0x40, idle ack, then MEM store vs IF fetch collision
    vin[0]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0};
    vin[1]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h3C010001};
    vin[2]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0};
    vin[3]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'hFFFFFFFF};
    vin[4]  = '{1'b1, 32'h44, 1'b1, 1'b1, 32'h100, 4'h3, 32'hDEADBEEF, 1'b0, 32'h0};
    vin[5]  = '{1'b1, 32'h44, 1'b1, 1'b1, 32'h100, 4'h3, 32'hDEADBEEF, 1'b0, 32'h0};
    vin[6]  = '{1'b1, 32'h44, 1'b1, 1'b1, 32'h999, 4'hC, 32'h11111111, 1'b0, 32'h0};
    vin[7]  = '{1'b1, 32'h44, 1'b1, 1'b1, 32'h100, 4'h3, 32'hDEADBEEF, 1'b1, 32'h12345678};
    vin[8]  = '{1'b1, 32'h44, 1'b1, 1'b1, 32'h100, 4'h3, 32'hDEADBEEF, 1'b0, 32'h0};
    vin[9]  = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0};
    vin[10] = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0};
    vin[11] = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h8C220004};
    vin[12] = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0};
    vin[13] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0};

    vexp[0]  = '{1'b0, 1'b0, 32'h0,   4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0};
    vexp[1]  = '{1'b1, 1'b0, 32'h40,  4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0};
    vexp[2]  = '{1'b0, 1'b0, 32'h40,  4'hF, 32'h0, 1'b1, 1'b0, 32'h3C010001, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    vexp[3]  = '{1'b0, 1'b0, 32'h40,  4'hF, 32'h0, 1'b0, 1'b0, 32'h3C010001, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    vexp[4]  = '{1'b0, 1'b0, 32'h40,  4'hF, 32'h0, 1'b0, 1'b0, 32'h3C010001, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1};
    vexp[5]  = '{1'b1, 1'b1, 32'h100, 4'h3, 32'hDEADBEEF, 1'b0, 1'b0, 32'h3C010001, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1};
    vexp[6]  = '{1'b1, 1'b1, 32'h100, 4'h3, 32'hDEADBEEF, 1'b0, 1'b0, 32'h3C010001, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1};
    vexp[7]  = '{1'b1, 1'b1, 32'h100, 4'h3, 32'hDEADBEEF, 1'b0, 1'b0, 32'h3C010001, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1};
    vexp[8]  = '{1'b0, 1'b1, 32'h100, 4'h3, 32'hDEADBEEF, 1'b0, 1'b0, 32'h3C010001, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0};
    vexp[9]  = '{1'b1, 1'b0, 32'h44,  4'hF, 32'h0, 1'b0, 1'b0, 32'h3C010001, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0};
    vexp[10] = '{1'b1, 1'b0, 32'h44,  4'hF, 32'h0, 1'b0, 1'b0, 32'h3C010001, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0};
    vexp[11] = '{1'b1, 1'b0, 32'h44,  4'hF, 32'h0, 1'b0, 1'b0, 32'h3C010001, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0};
    vexp[12] = '{1'b0, 1'b0, 32'h44,  4'hF, 32'h0, 1'b1, 1'b0, 32'h8C220004, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    vexp[13] = '{1'b0, 1'b0, 32'h44,  4'hF, 32'h0, 1'b0, 1'b0, 32'h8C220004, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};

    drive_idle();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    chk("reset bus_req", 32'(bus_req), 32'd0);
    chk("reset bus_addr", bus_addr, 32'd0);
    chk("reset if_ready", 32'(if_ready), 32'd0);
    chk("reset mem_ready", 32'(mem_ready), 32'd0);
    chk("reset state", 32'(arb_state), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clock);
      apply_vec(vin[i]);
      #1;
      check_vec(i, vexp[i]);
    end

    // both masters held: grants must alternate MEM, IF, MEM, IF, MEM, IF
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(32'h200);
      exp_q.push_back(32'h1000);
    end
    grants = 0;
    prev_req = 0;
    for (int c = 0; c < 100 && grants < 6; c++) begin
      @(negedge clock);
      mem_req = 1; mem_we = 0; mem_addr = 32'h200; mem_sel = 4'hF;
      if_req = 1; if_addr = 32'h1000;
      bus_ack = bus_req;
      bus_rdata = 32'hA5A50000 | 32'(c);
      #1;
      if (bus_req && !prev_req) begin
        chk($sformatf("alt grant%0d addr", grants), bus_addr, exp_q.pop_front());
        grants++;
      end
      prev_req = bus_req;
      chk("alt ready_overlap", 32'(if_ready & mem_ready), 32'd0);
    end
    chk("alt grants_done", 32'(exp_q.size()), 32'd0);
    @(negedge clock);
    mem_req = 0; bus_ack = 0;
    #1;
    chk("alt last if_ready", 32'(if_ready), 32'd1);
    @(negedge clock);
    drive_idle();
    #1;
    chk("alt mem_rdata_loaded", 32'(mem_rdata[31:16]), 32'hA5A5);

    mem_load_watchdog("timeout", 0, 1'b1, 32'h0);
    mem_load_watchdog("ack_at_16", 16, 1'b0, 32'h0BADF00D);

    // asynchronous reset during GRANT_IF, then the held fetch restarts
    @(negedge clock);
    if_req = 1; if_addr = 32'h500;
    seen = 0;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(negedge clock);
      #1;
      seen = bus_req;
    end
    chk("rst grant_seen", 32'(seen), 32'd1);
    chk("rst pre state", 32'(arb_state), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rst bus_req_immediate", 32'(bus_req), 32'd0);
    chk("rst bus_addr_cleared", bus_addr, 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      #1;
      chk("rst no_if_ready", 32'(if_ready), 32'd0);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst idle bus_req", 32'(bus_req), 32'd0);
    @(negedge clock);
    #1;
    chk("rst regrant bus_req", 32'(bus_req), 32'd1);
    chk("rst regrant bus_addr", bus_addr, 32'h500);
    chk("rst regrant bus_sel", 32'(bus_sel), 32'hF);
    bus_ack = 1; bus_rdata = 32'h24020005;
    @(negedge clock);
    bus_ack = 0;
    #1;
    chk("rst if_ready", 32'(if_ready), 32'd1);
    chk("rst if_error", 32'(if_error), 32'd0);
    chk("rst if_rdata", if_rdata, 32'h24020005);
    @(negedge clock);
    drive_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares one external memory bus between instruction fetch (IF) and data access (MEM) once loads/stores land; bus is req/ack with variable wait states. Sits beside pc_reg and mem, drives stall requests into control, which freezes the pipeline while an access is outstanding. MEM has fixed priority (older instruction); a per-transaction watchdog aborts a hung slave.

Parameters:
TIMEOUT_CYCLES, 16, cycles in a grant state without bus_ack before abort (>=1)
COUNT_WIDTH, 5, watchdog counter width; must hold TIMEOUT_CYCLES

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; all state and outputs cleared immediately
if_req  in  1  fetch request, held until if_ready
if_addr  in  32  fetch address, word aligned
if_rdata  out  32  fetched instruction, registered, held until next IF completion
if_ready  out  1  one-cycle completion pulse for IF
if_error  out  1  one-cycle pulse with if_ready when IF access timed out
stall_from_if  out  1  if_req && !if_ready
mem_req  in  1  data request, held until mem_ready
mem_we  in  1  1 = store
mem_addr  in  32  data address
mem_sel  in  4  byte lane enables
mem_wdata  in  32  store data
mem_rdata  out  32  load data, registered, held until next MEM completion
mem_ready  out  1  one-cycle completion pulse for MEM
mem_error  out  1  one-cycle pulse with mem_ready on timeout
stall_from_mem  out  1  mem_req && !mem_ready
bus_req  out  1  registered, high from cycle after grant until ack/abort
bus_we  out  1  registered; 0 for IF
bus_addr  out  32  registered, latched at grant
bus_sel  out  4  registered; 4'b1111 for IF
bus_wdata  out  32  registered; 0 for IF
bus_rdata  in  32  slave read data, valid with bus_ack
bus_ack  in  1  slave completion, single cycle

Behaviour:
- Reset values: all outputs 0; state IDLE; counter 0. Reset mid-transaction drops bus_req at once; partial transfer discarded, no ready pulse.
- FSM states: IDLE, GRANT_IF, GRANT_MEM (encoded 2 bits).
- IDLE: eff_mem = mem_req && !mem_ready; eff_if = if_req && !if_ready (a master's req is masked during its own ready cycle, as the pipeline advances on that edge). eff_mem -> GRANT_MEM; else eff_if -> GRANT_IF; else stay. On transition, latch bus_* from the winner and set bus_req=1, counter=0.
- GRANT_x: bus outputs stable. bus_ack=1 -> capture bus_rdata into x_rdata (stores: x_rdata unchanged), pulse x_ready next cycle, bus_req=0, -> IDLE.
- Watchdog: counter increments each GRANT cycle without ack; at counter == TIMEOUT_CYCLES-1 with no ack -> bus_req=0, x_rdata=0, x_ready=1 and x_error=1 next cycle, -> IDLE. Ack and timeout in the same cycle: ack wins, no error.
- Minimum latency: req in cycle 0, bus_req cycle 1, ack cycle 1, ready cycle 2 (stall high cycles 0-1).
- Both requesting continuously: MEM, then IF (MEM masked in its ready cycle), then MEM; never two consecutive grants to the same master while the other waits.
- bus_ack in IDLE ignored. Requester changes addr while pending: no effect, latched value used.
- Ready pulses never overlap for IF and MEM.

Decomposition:
- macro.v: ARB_STATE_BUS and ARB_STATE_IDLE/GRANT_IF/GRANT_MEM, MEM_ADDR_BUS, MEM_DATA_BUS, MEM_SEL_BUS.
- One sub-module natural: bus_watchdog (clear, enable, parameterised compare, expired output); remainder flat.
- control gains stall_from_if/stall_from_mem inputs (separate change).

Test Plan:
- Reset, IF req addr 0x00000040, ack at cycle 1 with rdata 0x3C010001 -> bus_addr 0x40 sel 4'hF cycle 1, if_ready and if_rdata 0x3C010001 at cycle 2, stall_from_if high cycles 0-1.
- IF and MEM store (0x100, sel 4'h3, wdata 0xDEADBEEF) in same cycle, ack after 2 wait states each -> MEM bus cycle first with bus_we=1, then IF; mem_ready precedes if_ready by 4 cycles.
- Both held continuously for 6 transactions -> grants alternate MEM, IF, MEM, IF, ...
- MEM load, no ack, TIMEOUT_CYCLES=16 -> bus_req drops after 16 cycles, mem_ready=mem_error=1 one cycle, mem_rdata 0; ack on cycle 16 instead -> no error.
- Assert reset while GRANT_IF with bus_req high -> bus_req 0 same cycle, no if_ready; after release, pending IF restarts from IDLE.
